// File: rtl/quad_encoder_gen.sv
// Quadrature x/y generator: turns (direction, step count) commands into timed
// Gray-code sequences that always start and end at the 11 detent.
module quad_encoder_gen #(
  parameter int CNT_WIDTH = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_dir_i,
  input  logic [CNT_WIDTH-1:0] cmd_steps_i,
  input  logic [DIV_WIDTH-1:0] phase_len_i,
  output logic                 x_o,
  output logic                 y_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] position_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_P4   = 3'd5
  } state_e;

  // x/y code for a phase; anything that is not P1..P3 rests at detent 11.
  function automatic logic [1:0] phase_xy(input state_e st, input logic up);
    logic [1:0] xy;
    case (st)
      ST_P1:   xy = up ? 2'b10 : 2'b01;
      ST_P2:   xy = 2'b00;
      ST_P3:   xy = up ? 2'b01 : 2'b10;
      default: xy = 2'b11;
    endcase
    return xy;
  endfunction

  logic [1:0]           rst_sync_q;
  logic                 rst_int_n;
  state_e               state_q;
  state_e               next_phase_s;
  logic                 dir_q;
  logic [CNT_WIDTH-1:0] steps_q;
  logic [DIV_WIDTH-1:0] len_m1_q;
  logic [DIV_WIDTH-1:0] timer_q;
  logic                 x_q;
  logic                 y_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] pos_q;
  logic [DIV_WIDTH-1:0] len_m1_d;
  logic [CNT_WIDTH-1:0] pos_d;
  logic                 phase_end_s;
  logic                 last_step_s;

  // Reset asserts asynchronously but is released only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Combinational helpers: clamped phase reload, next phase, position step.
  always_comb begin
    len_m1_d     = (phase_len_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : (phase_len_i - DIV_WIDTH'(1));
    pos_d        = dir_q ? (pos_q + CNT_WIDTH'(1)) : (pos_q - CNT_WIDTH'(1));
    phase_end_s  = (timer_q == '0);
    last_step_s  = (steps_q == CNT_WIDTH'(1));
    next_phase_s = ST_IDLE;
    case (state_q)
      ST_P1:   next_phase_s = ST_P2;
      ST_P2:   next_phase_s = ST_P3;
      ST_P3:   next_phase_s = ST_P4;
      default: next_phase_s = ST_IDLE;
    endcase
  end

  // Step sequencer: handshake, phase timing, position and all registered outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      steps_q  <= '0;
      len_m1_q <= '0;
      timer_q  <= '0;
      x_q      <= 1'b1;
      y_q      <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      pos_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          x_q     <= 1'b1;
          y_q     <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          if (cmd_valid_i && ready_q) begin
            dir_q    <= cmd_dir_i;
            steps_q  <= cmd_steps_i;
            len_m1_q <= len_m1_d;
            ready_q  <= 1'b0;
            state_q  <= ST_ARM;
          end
        end
        // One settling cycle between acceptance and the first phase.
        ST_ARM: begin
          if (steps_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            state_q    <= ST_P1;
            {x_q, y_q} <= phase_xy(ST_P1, dir_q);
            busy_q     <= 1'b1;
            timer_q    <= len_m1_q;
          end
        end
        ST_P1, ST_P2, ST_P3: begin
          if (phase_end_s) begin
            state_q    <= next_phase_s;
            {x_q, y_q} <= phase_xy(next_phase_s, dir_q);
            timer_q    <= len_m1_q;
          end else begin
            timer_q <= timer_q - DIV_WIDTH'(1);
          end
        end
        ST_P4: begin
          if (phase_end_s) begin
            pos_q   <= pos_d;
            steps_q <= steps_q - CNT_WIDTH'(1);
            timer_q <= len_m1_q;
            if (last_step_s) begin
              state_q <= ST_IDLE;
              x_q     <= 1'b1;
              y_q     <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              state_q    <= ST_P1;
              {x_q, y_q} <= phase_xy(ST_P1, dir_q);
            end
          end else begin
            timer_q <= timer_q - DIV_WIDTH'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          x_q     <= 1'b1;
          y_q     <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign position_o  = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: per-cycle expected traces are queued when a
// command is driven and compared as the generator plays them out.
module tb_quad_encoder_gen;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [7:0]  cmd_steps;
  logic [15:0] phase_len;
  logic        x;
  logic        y;
  logic        busy;
  logic        done;
  logic [7:0]  position;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [12:0] exp_q[$];
  logic [7:0]  exp_pos  = 8'd0;
  logic [1:0]  dec_prev = 2'b11;
  int          dec_cnt  = 0;

  quad_encoder_gen #(.CNT_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_dir_i  (cmd_dir),
    .cmd_steps_i(cmd_steps),
    .phase_len_i(phase_len),
    .x_o        (x),
    .y_o        (y),
    .busy_o     (busy),
    .done_o     (done),
    .position_o (position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference panel decoder: one count per completed detent-to-detent step.
  always @(posedge clk) begin
    dec_prev <= {x, y};
    if (dec_prev == 2'b01 && {x, y} == 2'b11) dec_cnt <= dec_cnt + 1;
    else if (dec_prev == 2'b10 && {x, y} == 2'b11) dec_cnt <= dec_cnt - 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] obs();
    return {cmd_ready, x, y, busy, done, position};
  endfunction

  task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (ready,x,y,busy,done,pos)", tag, o, e);
    end
  endtask

  // Expected trace from the acceptance edge (k=0) to the done cycle.
  task automatic push_expect(input logic up, input int steps, input int plen);
    int L;
    int K;
    int st;
    int ph;
    logic [7:0] p;
    logic [7:0] st8;
    logic [1:0] xy;
    L = (plen < 2) ? 2 : plen;
    K = 4 * L * steps + 1;
    exp_q.push_back({1'b0, 2'b11, 1'b0, 1'b0, exp_pos});
    for (int k = 1; k <= K; k++) begin
      st  = (k - 1) / (4 * L);
      st8 = st[7:0];
      p   = up ? (exp_pos + st8) : (exp_pos - st8);
      if (k == K) begin
        exp_q.push_back({1'b1, 2'b11, 1'b0, 1'b1, p});
      end else begin
        ph = ((k - 1) / L) % 4;
        case (ph)
          0:       xy = up ? 2'b10 : 2'b01;
          1:       xy = 2'b00;
          2:       xy = up ? 2'b01 : 2'b10;
          default: xy = 2'b11;
        endcase
        exp_q.push_back({1'b0, xy, 1'b1, 1'b0, p});
      end
    end
    st8 = steps[7:0];
    exp_pos = up ? (exp_pos + st8) : (exp_pos - st8);
  endtask

  task automatic pop_check(input string tag);
    logic [12:0] e;
    e = exp_q.pop_front();
    check(tag, obs(), e);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      pop_check(tag);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {12'd0, cmd_ready}, 13'd1);
  endtask

  task automatic drive(input logic up, input int steps, input int plen);
    cmd_valid = 1'b1;
    cmd_dir   = up;
    cmd_steps = steps[7:0];
    phase_len = plen[15:0];
  endtask

  task automatic issue(input string tag, input logic up, input int steps, input int plen);
    wait_ready({tag, "_ready"});
    drive(up, steps, plen);
    push_expect(up, steps, plen);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pop_check(tag);
    drain(tag);
  endtask

  initial begin
    int d0;
    int diff;
    logic [7:0] p0;
    logic [7:0] pdiff;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = 8'd0;
    phase_len = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", obs(), {1'b0, 2'b11, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;

    issue("t1_up1_L4", 1'b1, 1, 4);
    check("t1_pos", {5'd0, position}, 13'd1);

    issue("t2_dn3_L2", 1'b0, 3, 2);
    check("t2_pos", {5'd0, position}, 13'd254);

    d0 = dec_cnt;
    p0 = position;
    issue("t3_up5_L0", 1'b1, 5, 0);
    issue("t3_dn2_L0", 1'b0, 2, 0);
    repeat (2) @(posedge clk);
    #1;
    diff  = dec_cnt - d0;
    pdiff = position - p0;
    check("t3_decoder", 13'(diff), 13'd3);
    check("t3_pos_delta", {5'd0, pdiff}, 13'd3);

    issue("t4_dn2", 1'b0, 2, 2);
    check("t4_pos255", {5'd0, position}, 13'd255);
    issue("t4_wrap", 1'b1, 1, 3);
    check("t4_pos0", {5'd0, position}, 13'd0);
    issue("t4_zero", 1'b1, 0, 5);

    // Command held with altered fields while busy, then taken in the done cycle.
    wait_ready("t6_ready");
    drive(1'b1, 2, 2);
    push_expect(1'b1, 2, 2);
    @(posedge clk); #1;
    drive(1'b0, 1, 3);
    pop_check("t6_first");
    drain("t6_first");
    push_expect(1'b0, 1, 3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pop_check("t6_b2b");
    drain("t6_b2b");
    check("t6_pos", {5'd0, position}, 13'd1);

    // Reset during P2 of a long command.
    wait_ready("t5_ready");
    drive(1'b1, 10, 4);
    push_expect(1'b1, 10, 4);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pop_check("t5_run");
    repeat (6) begin
      @(posedge clk); #1;
      pop_check("t5_run");
    end
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", obs(), {1'b0, 2'b11, 1'b0, 1'b0, 8'h00});
    exp_q.delete();
    exp_pos = 8'd0;
    repeat (2) begin
      @(posedge clk); #1;
      check("t5_hold", obs(), {1'b0, 2'b11, 1'b0, 1'b0, 8'h00});
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("t5_no_done", {8'd0, x, y, busy, done, 1'b0}, {8'd0, 2'b11, 1'b0, 1'b0, 1'b0});
    end
    issue("t5_after", 1'b1, 2, 3);
    check("t5_pos", {5'd0, position}, 13'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
